// File: rtl/mop_acc_regfile.sv
// Integer register file with a LANES x LANES outer-product accumulator tile mapped above the GPRs.
// Reads are combinational with writeback forwarding; MOP sequences update one tile row per cycle.
module mop_acc_regfile #(
  parameter int XLEN    = 32,
  parameter int ELEM_W  = 8,
  parameter int LANES   = XLEN / ELEM_W,
  parameter int NUM_GPR = 32,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_regs_addr1,
  input  logic [ADDR_W-1:0] r_regs_addr2,
  output logic [XLEN-1:0]   r_regs_o1,
  output logic [XLEN-1:0]   r_regs_o2,
  input  logic              w_regs_en,
  input  logic [ADDR_W-1:0] w_regs_addr,
  input  logic [XLEN-1:0]   w_regs_data,
  input  logic              mop_valid,
  output logic              mop_ready,
  input  logic [1:0]        mop_mode,
  input  logic [XLEN-1:0]   mop_a,
  input  logic [XLEN-1:0]   mop_b,
  output logic              mop_busy,
  output logic              mop_done,
  output logic              acc_wr_err
);

  localparam int NREG  = NUM_GPR + LANES;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(LANES - 1);
  localparam logic [2*ELEM_W:0] ELEM_MAX = {{(ELEM_W+1){1'b0}}, {ELEM_W{1'b1}}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [XLEN-1:0]   regs [NREG];
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   lat_a;
  logic [XLEN-1:0]   lat_b;
  logic [1:0]        lat_mode;
  logic [ADDR_W-1:0] row_addr;
  logic [XLEN-1:0]   upd_row;
  logic              wr_ok;

  function automatic logic is_gpr(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_GPR);
  endfunction

  function automatic logic is_tile(input logic [ADDR_W-1:0] a);
    return (int'(a) >= NUM_GPR) && (int'(a) < NREG);
  endfunction

  // Tile rows are locked against direct writes while a sequence owns them.
  assign wr_ok = w_regs_en &&
                 (is_gpr(w_regs_addr) || (is_tile(w_regs_addr) && state == IDLE));

  function automatic logic [XLEN-1:0] rd_port(input logic [ADDR_W-1:0] a);
    if (wr_ok && w_regs_addr == a)
      return w_regs_data;
    else if (is_gpr(a) || is_tile(a))
      return regs[a];
    else
      return '0;
  endfunction

  assign r_regs_o1 = rd_port(r_regs_addr1);
  assign r_regs_o2 = rd_port(r_regs_addr2);
  assign mop_ready = (state == IDLE);
  assign mop_busy  = (state == BUSY);
  assign row_addr  = ADDR_W'(NUM_GPR) + ADDR_W'(cnt);

  always_comb begin
    logic [ELEM_W-1:0]   b_i;
    logic [ELEM_W-1:0]   acc;
    logic [ELEM_W-1:0]   nxt;
    logic [2*ELEM_W-1:0] prod;
    logic [2*ELEM_W:0]   sum;
    upd_row = '0;
    b_i     = lat_b[cnt*ELEM_W +: ELEM_W];
    acc     = '0;
    nxt     = '0;
    prod    = '0;
    sum     = '0;
    for (int k = 0; k < LANES; k++) begin
      acc  = regs[row_addr][k*ELEM_W +: ELEM_W];
      prod = {{ELEM_W{1'b0}}, lat_a[k*ELEM_W +: ELEM_W]} * {{ELEM_W{1'b0}}, b_i};
      sum  = {1'b0, prod} + {{(ELEM_W+1){1'b0}}, acc};
      case (lat_mode)
        2'b00:   nxt = sum[ELEM_W-1:0];
        2'b01:   nxt = (sum > ELEM_MAX) ? {ELEM_W{1'b1}} : sum[ELEM_W-1:0];
        2'b10:   nxt = prod[ELEM_W-1:0];
        default: nxt = '0;
      endcase
      upd_row[k*ELEM_W +: ELEM_W] = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      state      <= IDLE;
      cnt        <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_mode   <= '0;
      mop_done   <= 1'b0;
      acc_wr_err <= 1'b0;
    end else begin
      mop_done   <= 1'b0;
      acc_wr_err <= w_regs_en && is_tile(w_regs_addr) && (state == BUSY);
      if (wr_ok) regs[w_regs_addr] <= w_regs_data;
      case (state)
        IDLE: begin
          if (mop_valid) begin
            lat_a    <= mop_a;
            lat_b    <= mop_b;
            lat_mode <= mop_mode;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          regs[row_addr] <= upd_row;
          cnt            <= cnt + 1'b1;
          if (cnt == LAST_ROW) begin
            state    <= IDLE;
            mop_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
